// File: rtl/alu_seq.sv
// alu_seq: handshaked, parameterised ALU between operand fetch and writeback.
// Single-cycle ops resolve at accept. Iterative shifts and MUL step once per
// cycle in BUSY. The result and flags are registered and held in DONE until
// the consumer takes them.
module alu_seq #(
    parameter int WIDTH      = 16,
    parameter bit ITER_SHIFT = 1'b1,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    localparam int SH_W = $clog2(WIDTH) + 1;
    localparam logic [SH_W-1:0] SH_MAX = SH_W'(WIDTH);

    localparam logic [3:0] OP_NAND = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NOR  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SL   = 4'd7;
    localparam logic [3:0] OP_SR   = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        func_q, func_d;
    logic [WIDTH-1:0]  work_q, work_d;     // shift operand / MUL multiplicand
    logic [WIDTH-1:0]  mplier_q, mplier_d; // MUL multiplier, consumed LSB first
    logic [WIDTH-1:0]  acc_q, acc_d;       // MUL partial product
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, ill_q, ill_d;

    // Request decode and single-cycle result, computed from the live inputs
    logic [SH_W-1:0]   sh_n;
    logic [WIDTH-1:0]  res1;
    logic              c1, v1, ill1, is_shift, is_mul;

    always_comb begin
        sh_n     = (b[SH_W-1:0] > SH_MAX) ? SH_MAX : b[SH_W-1:0];
        res1     = '0;
        c1       = 1'b0;
        v1       = 1'b0;
        ill1     = 1'b0;
        is_shift = 1'b0;
        is_mul   = 1'b0;
        case (func)
            OP_NAND: res1 = ~(a & b);
            OP_AND:  res1 = a & b;
            OP_NOR:  res1 = ~(a | b);
            OP_OR:   res1 = a | b;
            OP_XOR:  res1 = a ^ b;
            OP_ADD: begin
                {c1, res1} = {1'b0, a} + {1'b0, b};
                v1 = (a[WIDTH-1] == b[WIDTH-1]) && (res1[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the (WIDTH+1)-bit difference is the borrow (a < b)
                {c1, res1} = {1'b0, a} - {1'b0, b};
                v1 = (a[WIDTH-1] != b[WIDTH-1]) && (res1[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SL, OP_SR, OP_SRA: begin
                is_shift = 1'b1;
                // Iterative build only resolves n == 0 here, which is identity
                if (ITER_SHIFT)            res1 = a;
                else if (func == OP_SL)    res1 = a << sh_n;
                else if (func == OP_SR)    res1 = a >> sh_n;
                else                       res1 = $signed(a) >>> sh_n;
            end
            OP_MUL: begin
                is_mul = ENABLE_MUL;
                ill1   = !ENABLE_MUL;
            end
            default: ill1 = 1'b1;
        endcase
    end

    // One BUSY step: shift the work register by one bit, or do one shift-add
    logic [WIDTH-1:0] work_step, acc_step;

    always_comb begin
        acc_step = acc_q;
        case (func_q)
            OP_SL:   work_step = {work_q[WIDTH-2:0], 1'b0};
            OP_SR:   work_step = {1'b0, work_q[WIDTH-1:1]};
            OP_SRA:  work_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: begin
                work_step = {work_q[WIDTH-2:0], 1'b0};
                if (mplier_q[0]) acc_step = acc_q + work_q;
            end
        endcase
    end

    // FSM next state, datapath registers and result/flag capture
    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        work_d   = work_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        ill_d    = ill_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    func_d = func;
                    if (is_mul) begin
                        work_d   = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = SH_MAX;
                        state_d  = S_BUSY;
                    end else if (ITER_SHIFT && is_shift && sh_n != '0) begin
                        work_d  = a;
                        cnt_d   = sh_n;
                        state_d = S_BUSY;
                    end else begin
                        out_d   = ill1 ? '0 : res1;
                        z_d     = (out_d == '0);
                        n_d     = out_d[WIDTH-1];
                        c_d     = c1 && !ill1;
                        v_d     = v1 && !ill1;
                        ill_d   = ill1;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                work_d   = work_step;
                acc_d    = acc_step;
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == SH_W'(1)) begin
                    out_d   = (func_q == OP_MUL) ? acc_step : work_step;
                    z_d     = (out_d == '0);
                    n_d     = out_d[WIDTH-1];
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    ill_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            func_q   <= '0;
            work_q   <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            work_q   <= work_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign flag_z    = z_q;
    assign flag_n    = n_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed + randomized checks of alu_seq (WIDTH=16, iterative
// shifts, MUL enabled) against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  func;
    logic [15:0] a, b, out_w;
    logic        flag_z, flag_n, flag_c, flag_v, illegal;
    int          checks = 0;
    int          fails  = 0;

    alu_seq #(.WIDTH(16), .ITER_SHIFT(1'b1), .ENABLE_MUL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .func(func), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out_w), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .flag_v(flag_v), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sval(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    // Reference: result, C, V, illegal and cycles from accept to out_valid
    function automatic void model(input logic [3:0] f, input logic [15:0] av, bv,
                                  output logic [15:0] r, output logic c, v, il,
                                  output int lat);
        int n, s, t;
        longint p;
        n = int'(bv[4:0]);
        if (n > 16) n = 16;
        r = 16'h0; c = 1'b0; v = 1'b0; il = 1'b0; lat = 1;
        case (f)
            4'd0: r = ~(av & bv);
            4'd1: r = av & bv;
            4'd2: r = ~(av | bv);
            4'd3: r = av | bv;
            4'd6: r = av ^ bv;
            4'd4: begin
                s = int'(av) + int'(bv); r = s[15:0]; c = (s > 65535);
                t = sval(av) + sval(bv); v = (t > 32767) || (t < -32768);
            end
            4'd5: begin
                s = int'(av) - int'(bv); r = s[15:0]; c = (av < bv);
                t = sval(av) - sval(bv); v = (t > 32767) || (t < -32768);
            end
            4'd7: begin s = int'(av) << n; r = s[15:0]; lat = 1 + n; end
            4'd8: begin s = int'(av) >> n; r = s[15:0]; lat = 1 + n; end
            4'd9: begin s = sval(av) >>> n; r = s[15:0]; lat = 1 + n; end
            4'd10: begin p = longint'(av) * longint'(bv); r = p[15:0]; lat = 17; end
            default: il = 1'b1;
        endcase
    endfunction

    // Issue one op, wait for the result, check it, hold it, then release it
    task automatic run_op(input logic [3:0] f, input logic [15:0] av, bv, input int hold);
        logic [15:0] er;
        logic        ec, ev, eil;
        int          elat, cyc;
        model(f, av, bv, er, ec, ev, eil, elat);
        @(negedge clk);
        in_valid = 1'b1; func = f; a = av; b = bv;
        check("accept_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        a = 16'($urandom); b = 16'($urandom); func = 4'($urandom);
        in_valid = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            check("busy_rdy", in_ready, 0);
            in_valid = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", cyc, elat);
        check("out", out_w, er);
        check("flag_z", flag_z, (er == 16'h0));
        check("flag_n", flag_n, er[15]);
        check("flag_c", flag_c, ec);
        check("flag_v", flag_v, ev);
        check("illegal", illegal, eil);
        repeat (hold) begin
            @(negedge clk);
            check("hold_out", {out_valid, in_ready, flag_z, flag_n, flag_c, flag_v, out_w},
                  {1'b1, 1'b0, er == 16'h0, er[15], ec, ev, er});
        end
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_vld", out_valid, 0);
        check("post_rdy", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        func = 4'h0; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_rdy", in_ready, 0);
        check("rst_state", {out_valid, illegal, flag_z, flag_n, flag_c, flag_v, out_w}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_rdy", in_ready, 1);

        run_op(4'd4, 16'h7FFF, 16'h0001, 0);
        run_op(4'd5, 16'h0003, 16'h0005, 0);
        run_op(4'd4, 16'hFFFF, 16'h0001, 0);
        run_op(4'd7, 16'h0001, 16'h0003, 0);
        run_op(4'd9, 16'h8000, 16'h000F, 0);
        run_op(4'd8, 16'hFFFF, 16'h0013, 0);
        run_op(4'd9, 16'h8001, 16'h001F, 0);
        run_op(4'd7, 16'h1234, 16'h0000, 0);
        run_op(4'd10, 16'h0102, 16'h0304, 0);
        run_op(4'd12, 16'h1234, 16'h5678, 0);
        run_op(4'd4, 16'h1111, 16'h2222, 5);

        // Reset in the middle of a MUL
        @(negedge clk);
        in_valid = 1'b1; func = 4'd10; a = 16'h0102; b = 16'h0304;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1 check("midrst_rdy_low", in_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_state", {out_valid, illegal, flag_z, flag_n, flag_c, flag_v, out_w}, 0);
        check("midrst_rdy", in_ready, 1);
        run_op(4'd4, 16'h0005, 16'h0007, 1);

        for (int i = 0; i < 80; i++) begin
            logic [15:0] rb;
            rb = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rb = rb & 16'h001F;
            run_op(4'($urandom_range(0, 15)), 16'($urandom), rb, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
